tdm_demux2: RTL and testbench



---
 rtl/tdm_demux2.sv | 91 +++++++++
 tb/tb_tdm_demux2.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux2.sv
// Two-channel TDM receive stage: splits slot 0 / slot 1 samples into registered
// channel outputs, tracks sync-marker alignment and counts completed frames.
module tdm_demux2 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] oa,
    output logic [WIDTH-1:0] ob,
    output logic             oa_vld,
    output logic             ob_vld,
    output logic             locked,
    output logic             sync_err,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t             state_q;
    logic               slot_q;
    logic [WIDTH-1:0]   oa_q;
    logic [WIDTH-1:0]   ob_q;
    logic               oa_vld_q;
    logic               ob_vld_q;
    logic               sync_err_q;
    logic [CNT_W-1:0]   cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            slot_q     <= 1'b0;
            oa_q       <= '0;
            ob_q       <= '0;
            oa_vld_q   <= 1'b0;
            ob_vld_q   <= 1'b0;
            sync_err_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            oa_vld_q   <= 1'b0;
            ob_vld_q   <= 1'b0;
            sync_err_q <= 1'b0;
            if (din_valid) begin
                case (state_q)
                    HUNT: begin
                        if (sync) begin
                            oa_q     <= din;
                            oa_vld_q <= 1'b1;
                            slot_q   <= 1'b1;
                            state_q  <= LOCK;
                        end
                    end
                    LOCK: begin
                        if (sync) begin
                            // An early sync restarts the frame rather than dropping lock.
                            sync_err_q <= slot_q;
                            oa_q       <= din;
                            oa_vld_q   <= 1'b1;
                            slot_q     <= 1'b1;
                        end else if (slot_q) begin
                            ob_q     <= din;
                            ob_vld_q <= 1'b1;
                            slot_q   <= 1'b0;
                            cnt_q    <= cnt_q + 1'b1;
                        end else begin
                            sync_err_q <= 1'b1;
                            slot_q     <= 1'b0;
                            state_q    <= HUNT;
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign oa        = oa_q;
    assign ob        = ob_q;
    assign oa_vld    = oa_vld_q;
    assign ob_vld    = ob_vld_q;
    assign locked    = (state_q == LOCK);
    assign sync_err  = sync_err_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_tdm_demux2.sv
// Self-checking bench for tdm_demux2: directed scenarios plus a random stream,
// all compared against a frame-level reference model.
module tb_tdm_demux2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       sync = 1'b0;
    logic [7:0] oa, ob, frame_cnt;
    logic       oa_vld, ob_vld, locked, sync_err;

    int checks = 0;
    int failures = 0;

    // Reference model state, described in frame terms
    logic [7:0] m_oa, m_ob, m_cnt;
    bit         m_oa_vld, m_ob_vld, m_err, m_locked, m_want_b;

    tdm_demux2 #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
        .oa(oa), .ob(ob), .oa_vld(oa_vld), .ob_vld(ob_vld),
        .locked(locked), .sync_err(sync_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] obs();
        return {oa, ob, oa_vld, ob_vld, locked, sync_err, frame_cnt};
    endfunction

    function automatic logic [27:0] expv();
        return {m_oa, m_ob, m_oa_vld, m_ob_vld, m_locked, m_err, m_cnt};
    endfunction

    task automatic model_clear();
        m_oa = 0; m_ob = 0; m_cnt = 0;
        m_oa_vld = 0; m_ob_vld = 0; m_err = 0; m_locked = 0; m_want_b = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; din_valid = 1'b0; sync = 1'b0;
        @(posedge clk); #1;
        model_clear();
        rst_n = 1'b1;
    endtask

    // One clock of stimulus; the model then applies the frame rules to it.
    task automatic step(input bit v, input bit s, input logic [7:0] d);
        @(negedge clk);
        din_valid = v; sync = s; din = d;
        @(posedge clk); #1;
        din_valid = 1'b0; sync = 1'b0;
        m_oa_vld = 0; m_ob_vld = 0; m_err = 0;
        if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_oa = d; m_oa_vld = 1; m_locked = 1; m_want_b = 1;
                end
            end else if (s) begin
                m_err = m_want_b;
                m_oa = d; m_oa_vld = 1; m_want_b = 1;
            end else if (m_want_b) begin
                m_ob = d; m_ob_vld = 1; m_want_b = 0; m_cnt = m_cnt + 8'd1;
            end else begin
                m_err = 1; m_locked = 0; m_want_b = 0;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs() !== 28'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", obs(), 28'h0);
        end
        step(1, 0, 8'h11);
        step(1, 0, 8'h22);
        checks++;
        if ({oa_vld, ob_vld, locked, sync_err, oa, ob} !== 20'h0) begin
            failures++;
            $display("FAIL hunt_discard got=%h exp=%h",
                     {oa_vld, ob_vld, locked, sync_err, oa, ob}, 20'h0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] dat [4] = '{8'hA1, 8'hB1, 8'hA2, 8'hB2};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, (i % 2) == 0, dat[i]);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL b2b_step%0d got=%h exp=%h", i, obs(), expv());
            end
            if (i == 0) begin
                checks++;
                if ({locked, oa_vld, oa} !== {1'b1, 1'b1, 8'hA1}) begin
                    failures++;
                    $display("FAIL b2b_first_lock got=%h exp=%h",
                             {locked, oa_vld, oa}, {1'b1, 1'b1, 8'hA1});
                end
            end
        end
        checks++;
        if ({frame_cnt, oa, ob} !== {8'd2, 8'hA2, 8'hB2}) begin
            failures++;
            $display("FAIL b2b_final got=%h exp=%h", {frame_cnt, oa, ob}, {8'd2, 8'hA2, 8'hB2});
        end
    endtask

    task automatic test_gaps();
        logic [7:0] dat [4] = '{8'hA1, 8'hB1, 8'hA2, 8'hB2};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, (i % 2) == 0, dat[i]);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL gap_sample%0d got=%h exp=%h", i, obs(), expv());
            end
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                step(0, $urandom_range(0, 1) == 1, 8'($urandom));
                checks++;
                if (obs() !== expv()) begin
                    failures++;
                    $display("FAIL gap_idle%0d_%0d got=%h exp=%h", i, g, obs(), expv());
                end
            end
        end
        checks++;
        if ({frame_cnt, oa, ob} !== {8'd2, 8'hA2, 8'hB2}) begin
            failures++;
            $display("FAIL gap_final got=%h exp=%h", {frame_cnt, oa, ob}, {8'd2, 8'hA2, 8'hB2});
        end
    endtask

    task automatic test_early_sync();
        do_reset();
        step(1, 1, 8'hA1);
        step(1, 1, 8'hC3);
        checks++;
        if ({sync_err, oa_vld, locked, oa, frame_cnt} !== {3'b111, 8'hC3, 8'd0}) begin
            failures++;
            $display("FAIL early_sync got=%h exp=%h",
                     {sync_err, oa_vld, locked, oa, frame_cnt}, {3'b111, 8'hC3, 8'd0});
        end
        step(1, 0, 8'hD3);
        checks++;
        if ({sync_err, ob_vld, ob, frame_cnt} !== {2'b01, 8'hD3, 8'd1}) begin
            failures++;
            $display("FAIL early_sync_b got=%h exp=%h",
                     {sync_err, ob_vld, ob, frame_cnt}, {2'b01, 8'hD3, 8'd1});
        end
    endtask

    task automatic test_missing_sync();
        do_reset();
        step(1, 1, 8'hA1);
        step(1, 0, 8'hB1);
        step(1, 0, 8'h55);
        checks++;
        if ({sync_err, oa_vld, ob_vld, locked, oa, ob} !== {4'b1000, 8'hA1, 8'hB1}) begin
            failures++;
            $display("FAIL missing_sync got=%h exp=%h",
                     {sync_err, oa_vld, ob_vld, locked, oa, ob}, {4'b1000, 8'hA1, 8'hB1});
        end
        step(1, 1, 8'h66);
        checks++;
        if ({sync_err, oa_vld, locked, oa} !== {3'b011, 8'h66}) begin
            failures++;
            $display("FAIL relock got=%h exp=%h", {sync_err, oa_vld, locked, oa}, {3'b011, 8'h66});
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int f = 0; f < 255; f++) begin
            step(1, 1, 8'($urandom));
            step(1, 0, 8'($urandom));
        end
        checks++;
        if (frame_cnt !== 8'd255) begin
            failures++;
            $display("FAIL wrap_pre got=%0d exp=%0d", frame_cnt, 255);
        end
        step(1, 1, 8'h01);
        step(1, 0, 8'h02);
        checks++;
        if ({frame_cnt, ob_vld, ob} !== {8'd0, 1'b1, 8'h02}) begin
            failures++;
            $display("FAIL wrap_zero got=%h exp=%h", {frame_cnt, ob_vld, ob}, {8'd0, 1'b1, 8'h02});
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        step(1, 1, 8'hA7);
        do_reset();
        checks++;
        if ({frame_cnt, locked, oa} !== 17'h0) begin
            failures++;
            $display("FAIL midframe_reset got=%h exp=%h", {frame_cnt, locked, oa}, 17'h0);
        end
        step(1, 0, 8'hB7);
        checks++;
        if ({ob_vld, ob, locked, frame_cnt, sync_err} !== 19'h0) begin
            failures++;
            $display("FAIL midframe_b_ignored got=%h exp=%h",
                     {ob_vld, ob, locked, frame_cnt, sync_err}, 19'h0);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 8'($urandom));
            checks++;
            if (obs() !== expv() || (oa_vld && ob_vld)) begin
                failures++;
                $display("FAIL random_step%0d got=%h exp=%h", i, obs(), expv());
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_back_to_back();
        test_gaps();
        test_early_sync();
        test_missing_sync();
        test_wrap();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
